// File: rtl/cg_pkg.sv
// Shared definitions for the vector dot-product unit.
//   no_of_units   : lanes per memory word
//   element_width : signed element width of each lane
//   state_e       : control FSM state encoding
package cg_pkg;

  localparam int no_of_units   = 8;
  localparam int element_width = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage : cg_pkg

// File: rtl/vector_dot_unit_lane_adder_tree.sv
// lane_adder_tree: registered signed sum of n_terms packed signed terms.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   terms_i    : n_terms signed values, term k at [k*term_width +: term_width]
//   sum_o      : registered sign-extended sum (one cycle latency)
module lane_adder_tree #(
  parameter int n_terms    = 8,
  parameter int term_width = 64,
  parameter int sum_width  = 67
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [n_terms*term_width-1:0] terms_i,
  output logic signed [sum_width-1:0]   sum_o
);

  logic signed [sum_width-1:0] sum_d;
  logic signed [sum_width-1:0] sum_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < n_terms; k++) begin
      sum_d = sum_d + sum_width'($signed(terms_i[k*term_width +: term_width]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule : lane_adder_tree

// File: rtl/vector_dot_unit.sv
// vector_dot_unit: streaming signed dot product of two vectors delivered as
// no_of_units-lane beats; three-stage pipeline (multiply, lane sum,
// accumulate) with a 64-bit saturated result and a one-cycle done pulse.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : begins one dot product (ignored unless idle)
//   total       : vector length in elements; total/8 beats are consumed
//   in_valid    : a_vec/b_vec beat valid
//   a_vec, b_vec: packed operand lanes, lane i at [i*element_width +: element_width]
//   read_now    : asks the address sequencer for the next beat
//   busy        : high from accepted start through the done pulse
//   result      : saturated signed dot product, held until the next result
//   vXv1_finish : one-cycle done pulse
module vector_dot_unit #(
  parameter int no_of_units   = cg_pkg::no_of_units,
  parameter int element_width = cg_pkg::element_width,
  parameter int acc_width     = 72
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic                                 in_valid,
  input  logic [no_of_units*element_width-1:0] a_vec,
  input  logic [no_of_units*element_width-1:0] b_vec,
  output logic                                 read_now,
  output logic                                 busy,
  output logic [63:0]                          result,
  output logic                                 vXv1_finish
);

  import cg_pkg::*;

  localparam int prod_width = 2 * element_width;
  localparam int sum_width  = prod_width + $clog2(no_of_units);

  localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};
  localparam logic signed [acc_width-1:0] res_max = acc_width'(64'sh7FFF_FFFF_FFFF_FFFF);
  localparam logic signed [acc_width-1:0] res_min = acc_width'(64'sh8000_0000_0000_0000);

  state_e      state_q;
  logic [31:0] target_q;
  logic [31:0] cnt_q;
  logic [1:0]  drain_q;
  logic        read_now_q;
  logic        busy_q;
  logic        finish_q;
  logic [63:0] result_q;

  logic [no_of_units*prod_width-1:0] prod_d;
  logic [no_of_units*prod_width-1:0] prod_q;
  logic signed [sum_width-1:0]       sum_q;
  logic signed [acc_width-1:0]       acc_d;
  logic signed [acc_width-1:0]       acc_q;
  logic signed [acc_width:0]         acc_sum;
  logic [63:0]                       sat_res;

  logic accept;
  logic start_ok;

  // read_now_q is high exactly while in RUN, so it doubles as the beat gate.
  assign accept   = read_now_q & in_valid;
  assign start_ok = start & (state_q == IDLE);

  // Stage 1 operands: bubbles register zero so the later stages need no valids.
  always_comb begin
    prod_d = '0;
    if (accept) begin
      for (int unsigned i = 0; i < no_of_units; i++) begin
        prod_d[i*prod_width +: prod_width] =
          prod_width'($signed(a_vec[i*element_width +: element_width])) *
          prod_width'($signed(b_vec[i*element_width +: element_width]));
      end
    end
  end

  lane_adder_tree #(
    .n_terms   (no_of_units),
    .term_width(prod_width),
    .sum_width (sum_width)
  ) u_tree (
    .clk    (clk),
    .reset  (reset),
    .terms_i(prod_q),
    .sum_o  (sum_q)
  );

  // The accumulator clamps at its own range instead of wrapping, so a long
  // vector of large products still ends at the correct saturated sign.
  always_comb begin
    acc_sum = (acc_width+1)'(acc_q) + (acc_width+1)'(sum_q);
    acc_d   = acc_sum[acc_width-1:0];
    if (acc_sum[acc_width] != acc_sum[acc_width-1]) begin
      acc_d = acc_sum[acc_width] ? acc_min : acc_max;
    end
  end

  always_comb begin
    sat_res = acc_q[63:0];
    if (acc_q > res_max) begin
      sat_res = 64'h7FFF_FFFF_FFFF_FFFF;
    end else if (acc_q < res_min) begin
      sat_res = 64'h8000_0000_0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= start_ok ? '0 : acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      read_now_q <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      result_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // DONE hands back to IDLE while the pulse is still out; busy
          // drops after the pulse unless a new start is taken right away.
          if (finish_q) begin
            busy_q <= 1'b0;
          end
          if (start) begin
            busy_q   <= 1'b1;
            target_q <= total >> 3;
            cnt_q    <= '0;
            if (total < 32'd8) begin
              state_q <= DONE;
            end else begin
              state_q    <= RUN;
              read_now_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt_q <= cnt_q + 32'd1;
            if (cnt_q + 32'd1 == target_q) begin
              state_q    <= DRAIN;
              read_now_q <= 1'b0;
              drain_q    <= '0;
            end
          end
        end
        DRAIN: begin
          drain_q <= drain_q + 2'd1;
          if (drain_q == 2'd2) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          finish_q <= 1'b1;
          result_q <= sat_res;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign read_now    = read_now_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign vXv1_finish = finish_q;

endmodule : vector_dot_unit

// File: tb/tb_vector_dot_unit.sv
module tb_vector_dot_unit;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  total;
  logic         in_valid;
  logic [255:0] a_vec;
  logic [255:0] b_vec;
  logic         read_now;
  logic         busy;
  logic [63:0]  result;
  logic         vXv1_finish;

  int checks;
  int failures;

  logic [255:0] a_mem [0:512];
  logic [255:0] b_mem [0:512];

  typedef struct {
    int unsigned total;
    int          kind;
    int          vmode;
    bit          pulse;
    logic [63:0] exp_res;
    int          exp_rn;
  } vec_t;

  vec_t tbl [8];

  vector_dot_unit #(
    .no_of_units  (8),
    .element_width(32),
    .acc_width    (72)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total      (total),
    .in_valid   (in_valid),
    .a_vec      (a_vec),
    .b_vec      (b_vec),
    .read_now   (read_now),
    .busy       (busy),
    .result     (result),
    .vXv1_finish(vXv1_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind 0: a=1,b=2; 1: a=lane+1,b=-1; 2: a=b=max; 3: a=min,b=max; else random
  task automatic fill(input int kind);
    for (int w = 0; w <= 512; w++) begin
      for (int l = 0; l < 8; l++) begin
        logic [31:0] av, bv;
        case (kind)
          0: begin av = 32'd1; bv = 32'd2; end
          1: begin av = 32'(l + 1); bv = 32'hFFFF_FFFF; end
          2: begin av = 32'h7FFF_FFFF; bv = 32'h7FFF_FFFF; end
          3: begin av = 32'h8000_0000; bv = 32'h7FFF_FFFF; end
          default: begin
            case ($urandom_range(0, 5))
              0: av = 32'h7FFF_FFFF;
              1: av = 32'h8000_0000;
              default: av = $urandom;
            endcase
            case ($urandom_range(0, 5))
              0: bv = 32'h7FFF_FFFF;
              1: bv = 32'h8000_0000;
              default: bv = $urandom;
            endcase
          end
        endcase
        a_mem[w][l*32 +: 32] = av;
        b_mem[w][l*32 +: 32] = bv;
      end
    end
  endtask

  // Exact dot product over the first total/8 words, clipped to 64-bit signed.
  function automatic logic [63:0] model(input int unsigned tot);
    logic signed [127:0] s;
    logic signed [127:0] maxv;
    logic signed [127:0] minv;
    maxv = 128'sh7FFF_FFFF_FFFF_FFFF;
    minv = -maxv - 128'sd1;
    s = '0;
    for (int w = 0; w < int'(tot / 8); w++) begin
      for (int l = 0; l < 8; l++) begin
        s = s + $signed(a_mem[w][l*32 +: 32]) * $signed(b_mem[w][l*32 +: 32]);
      end
    end
    if (s > maxv) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (s < minv) return 64'h8000_0000_0000_0000;
    return s[63:0];
  endfunction

  // Called at a negedge. lat: edges from last accepted beat to the done
  // pulse (or from the start edge when there are no beats).
  task automatic run_op(input int unsigned tot, input int vmode, input bit pulse,
                        output logic [63:0] res, output int lat, output int rn,
                        output bit done, output bit busy_fin);
    int cyc, beat, last, limit, idx;
    bit vld;
    limit = 8 * int'(tot / 8) + 50;
    start = 1'b1; total = tot; in_valid = 1'b0;
    cyc = 0; beat = 0; last = -1; rn = 0; done = 0; res = '0; lat = -1; busy_fin = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      start = (pulse && cyc == 1);
      if (pulse && cyc == 1) total = 32'd8;
      if (vXv1_finish) begin
        done = 1; res = result; busy_fin = busy;
        lat = (last < 0) ? cyc : cyc - last - 1;
      end else begin
        if (read_now) rn++;
        case (vmode)
          0: vld = 1'b1;
          1: vld = (cyc % 2 == 0);
          default: vld = ($urandom_range(0, 2) != 0);
        endcase
        idx = (beat > 512) ? 512 : beat;
        in_valid = vld; a_vec = a_mem[idx]; b_vec = b_mem[idx];
        if (read_now && vld) begin beat++; last = cyc; end
        cyc++;
      end
    end
    in_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [63:0] res, expv;
    int lat, rn, explat, seen;
    bit done, bfin;
    int unsigned tot;

    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; total = '0; in_valid = 1'b0; a_vec = '0; b_vec = '0;

    tbl[0] = '{16,   0, 0, 1'b0, 64'd32,                  2};
    tbl[1] = '{8,    1, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFDC, 1};
    tbl[2] = '{3,    0, 0, 1'b0, 64'd0,                   0};
    tbl[3] = '{4096, 2, 0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 512};
    tbl[4] = '{24,   0, 1, 1'b1, 64'd48,                  5};
    tbl[5] = '{8,    3, 0, 1'b0, 64'h8000_0000_0000_0000, 1};
    tbl[6] = '{15,   1, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFDC, 1};
    tbl[7] = '{24,   0, 0, 1'b0, 64'd48,                  3};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_read_now", 64'(read_now), 64'd0);
    chk("reset_finish", 64'(vXv1_finish), 64'd0);
    chk("reset_result", result, 64'd0);

    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].kind);
      run_op(tbl[i].total, tbl[i].vmode, tbl[i].pulse, res, lat, rn, done, bfin);
      explat = (tbl[i].total / 8 == 0) ? 1 : 4;
      chk($sformatf("vec%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(explat));
      chk($sformatf("vec%0d_read_now_cycles", i), 64'(rn), 64'(tbl[i].exp_rn));
      chk($sformatf("vec%0d_busy_at_done", i), 64'(bfin), 64'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after", i), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_finish_width", i), 64'(vXv1_finish), 64'd0);
    end

    for (int r = 0; r < 20; r++) begin
      tot = $urandom_range(0, 90);
      fill(9);
      expv = model(tot);
      run_op(tot, 2, 1'b0, res, lat, rn, done, bfin);
      explat = (tot / 8 == 0) ? 1 : 4;
      chk($sformatf("rand%0d_done", r), 64'(done), 64'd1);
      chk($sformatf("rand%0d_result", r), res, expv);
      chk($sformatf("rand%0d_latency", r), 64'(lat), 64'(explat));
      @(negedge clk);
      chk($sformatf("rand%0d_busy_after", r), 64'(busy), 64'd0);
    end

    // Reset while draining: abort with no done pulse and a cleared result.
    fill(0);
    run_op(8, 0, 1'b0, res, lat, rn, done, bfin);
    chk("pre_drain_result", res, 64'd16);
    @(negedge clk);
    fill(1);
    start = 1'b1; total = 32'd8;
    @(negedge clk);
    start = 1'b0;
    chk("drain_seq_read_now", 64'(read_now), 64'd1);
    in_valid = 1'b1; a_vec = a_mem[0]; b_vec = b_mem[0];
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_seq_in_drain_rn", 64'(read_now), 64'd0);
    chk("drain_seq_in_drain_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("drain_reset_busy", 64'(busy), 64'd0);
    chk("drain_reset_result", result, 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (vXv1_finish) seen++;
    end
    chk("drain_reset_no_finish", 64'(seen), 64'd0);

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; total = 32'd16;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_start_busy", 64'(busy), 64'd0);
    chk("reset_start_read_now", 64'(read_now), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (vXv1_finish || busy) seen++;
    end
    chk("reset_start_idle", 64'(seen), 64'd0);

    // Normal operation resumes after the aborted run.
    fill(1);
    run_op(16, 0, 1'b0, res, lat, rn, done, bfin);
    chk("recover_result", res, 64'hFFFF_FFFF_FFFF_FFB8);
    chk("recover_latency", 64'(lat), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vector_dot_unit

// File: doc/vector_dot_unit.md
VECTOR_DOT_UNIT -- requirements
Module: vector_dot_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  no_of_units, 8, lanes per memory word.
  element_width, 32, signed element width.
  acc_width, 72, internal accumulator width.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic on its rising edge.
  reset  in  1  synchronous, active-high reset.
  start  in  1  pulse; begins one dot product.
  total  in  32  vector length in elements; word count = total/8, remainder ignored.
  in_valid  in  1  a_vec/b_vec beat valid this cycle.
  a_vec  in  no_of_units*element_width  lanes of operand A; lane i at bits [32i+31:32i].
  b_vec  in  no_of_units*element_width  lanes of operand B, same packing.
  read_now  out  1  request to the address sequencer to advance its read pointers.
  busy  out  1  high from accepted start until done pulse inclusive.
  result  out  64  signed dot product, saturated; held until next accepted start.
  vXv1_finish  out  1  one-cycle done pulse.
REQ-003 Clock SHALL be named clk and reset named reset; reset is synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-005 IDLE -> RUN on start; word target latched as total/8 at that edge; beat counter cleared; accumulator cleared.
REQ-006 start while not IDLE SHALL be ignored.
REQ-007 If total/8 == 0 at start, IDLE -> DONE directly; result = 0.
REQ-008 In RUN, read_now SHALL be high while beats accepted < target; in_valid with read_now low SHALL be ignored.
REQ-009 Each accepted beat: stage 1 registers 8 signed 32x32 -> 64-bit products; stage 2 registers their sum (67-bit sign-extended); stage 3 adds into the acc_width accumulator.
REQ-010 RUN -> DRAIN on the edge the target-th beat is accepted; DRAIN lasts exactly 3 cycles to flush stages 1-3.
REQ-011 DRAIN -> DONE; in DONE vXv1_finish = 1 for one cycle, result updated that same cycle, then -> IDLE.
REQ-012 Latency: vXv1_finish SHALL assert 4 cycles after the last accepted beat edge.
REQ-013 result SHALL saturate to 64-bit signed max/min if the accumulator exceeds range; no wrap.
REQ-014 in_valid gaps SHALL be tolerated; pipeline advances only valid beats (bubbles carry zero).
REQ-015 Beat counter SHALL be 32 bits and never exceed target.

Reset
REQ-016 On reset: state = IDLE; busy, read_now, vXv1_finish = 0; result = 0; accumulator, pipeline registers and counters = 0.
REQ-017 Reset mid-RUN or mid-DRAIN SHALL abort without a done pulse; in-flight beats discarded.
REQ-018 reset and start in the same cycle: reset wins.

Structure
REQ-019 no_of_units, element_width and the FSM state encoding SHALL live in the shared cg_pkg package.
REQ-020 The registered 8-input signed adder tree SHALL be a sub-module named lane_adder_tree; all else stays in vector_dot_unit.

Verification
REQ-021 total=16, all lanes a=1,b=2, in_valid constant -> read_now high 2 cycles; vXv1_finish 4 cycles after beat 2; result=32.
REQ-022 total=8, a lanes = 1..8, b lanes = -1 each -> result=-36.
REQ-023 total=3 -> no read_now; vXv1_finish the cycle after DONE entry; result=0.
REQ-024 total=4096, every lane a=b=0x7FFFFFFF -> result=0x7FFFFFFFFFFFFFFF (saturated).
REQ-025 total=24, in_valid toggling 1,0,1,0,1 -> result equals gap-free run; start pulsed during RUN ignored.
REQ-026 reset asserted in DRAIN -> no vXv1_finish, busy=0 next cycle, result=0.
